// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame sequencer for the 3x3 convolution core.
// It walks a stride-1, no-padding 3x3 window over an IMG_H x IMG_W map held
// in a single-port pixel memory. The window goes to the core, and one
// rectified result per window is streamed out over a valid/ready port.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_start               frame start pulse (ignored while busy)
//   o_busy, o_done        frame in progress / one-cycle end-of-frame pulse
//   o_rdEn, o_rdAddr      pixel read strobe and address (y*IMG_W + x)
//   i_rdData              pixel data, valid one cycle after o_rdEn
//   o_window              9 x 10-bit window, slot 3*r+c at bits [10k+9:10k]
//   i_convData            core result, combinational from o_window
//   o_outData, o_outAddr  registered result and its index oy*(IMG_W-2)+ox
//   o_outValid, i_outReady  result handshake
module conv_window_ctrl #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rdEn,
  output logic [ADDR_W-1:0] o_rdAddr,
  input  logic [9:0]        i_rdData,
  output logic [89:0]       o_window,
  input  logic [9:0]        i_convData,
  output logic [9:0]        o_outData,
  output logic [ADDR_W-1:0] o_outAddr,
  output logic              o_outValid,
  input  logic              i_outReady
);

  localparam int unsigned PIX_W = 10;
  localparam int unsigned WIN_W = 9 * PIX_W;
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(IMG_H - 3);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, OUT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ox;
  logic [ADDR_W-1:0] oy;
  logic [ADDR_W-1:0] idx;         // running result index
  logic              shift_mode;  // current fetch reloads only column 2
  logic [3:0]        fcnt;        // cycles spent in FETCH
  logic [1:0]        cur_r;       // window coordinates of the read on the bus
  logic [1:0]        cur_c;
  logic              pend;        // a read issued last cycle returns data now
  logic [3:0]        pend_slot;
  logic [1:0]        nxt_r;
  logic [1:0]        nxt_c;
  logic [3:0]        nreads;
  logic              col_step;

  // Full fetches walk column-major; shift fetches walk rows of column 2 only.
  assign nreads   = shift_mode ? 4'd3 : 4'd9;
  assign col_step = !shift_mode && (cur_r == 2'd2);
  assign nxt_r    = col_step ? 2'd0 : cur_r + 2'd1;
  assign nxt_c    = col_step ? cur_c + 2'd1 : cur_c;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] y,
                                                 input logic [ADDR_W-1:0] x);
    return y * ROW_W + x;
  endfunction

  // Move columns 1,2 into columns 0,1; column 2 is refilled by the fetch.
  function automatic logic [WIN_W-1:0] shift_left(input logic [WIN_W-1:0] w);
    logic [WIN_W-1:0] s;
    s = w;
    for (int r = 0; r < 3; r++) begin
      s[30*r      +: PIX_W] = w[30*r + 10 +: PIX_W];
      s[30*r + 10 +: PIX_W] = w[30*r + 20 +: PIX_W];
    end
    return s;
  endfunction

  // Sequencer: state, counters, read issue, window capture and result port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdEn     <= 1'b0;
      o_rdAddr   <= '0;
      o_window   <= '0;
      o_outData  <= '0;
      o_outAddr  <= '0;
      o_outValid <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      idx        <= '0;
      shift_mode <= 1'b0;
      fcnt       <= '0;
      cur_r      <= '0;
      cur_c      <= '0;
      pend       <= 1'b0;
      pend_slot  <= '0;
    end else begin
      o_done    <= 1'b0;
      pend      <= o_rdEn;
      pend_slot <= 4'(3 * cur_r + cur_c);
      if (pend) begin
        o_window[PIX_W*pend_slot +: PIX_W] <= i_rdData;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= FETCH;
            o_busy     <= 1'b1;
            ox         <= '0;
            oy         <= '0;
            idx        <= '0;
            shift_mode <= 1'b0;
            fcnt       <= '0;
            cur_r      <= '0;
            cur_c      <= '0;
            o_rdEn     <= 1'b1;
            o_rdAddr   <= '0;
          end
        end

        FETCH: begin
          fcnt <= fcnt + 4'd1;
          if (fcnt == nreads) begin
            // last datum captured this cycle
            state <= CALC;
          end else if ((fcnt + 4'd1) < nreads) begin
            o_rdEn   <= 1'b1;
            cur_r    <= nxt_r;
            cur_c    <= nxt_c;
            o_rdAddr <= pix_addr(oy + ADDR_W'(nxt_r), ox + ADDR_W'(nxt_c));
          end else begin
            o_rdEn <= 1'b0;
          end
        end

        CALC: begin
          o_outData  <= i_convData;
          o_outAddr  <= idx;
          o_outValid <= 1'b1;
          state      <= OUT;
        end

        OUT: begin
          if (i_outReady) begin
            o_outValid <= 1'b0;
            idx        <= idx + ADDR_W'(1);
            fcnt       <= '0;
            if (ox < LAST_X) begin
              ox         <= ox + ADDR_W'(1);
              shift_mode <= 1'b1;
              cur_r      <= 2'd0;
              cur_c      <= 2'd2;
              o_rdEn     <= 1'b1;
              o_rdAddr   <= pix_addr(oy, ox + ADDR_W'(3));
              o_window   <= shift_left(o_window);
              state      <= FETCH;
            end else if (oy < LAST_Y) begin
              ox         <= '0;
              oy         <= oy + ADDR_W'(1);
              shift_mode <= 1'b0;
              cur_r      <= 2'd0;
              cur_c      <= 2'd0;
              o_rdEn     <= 1'b1;
              o_rdAddr   <= pix_addr(oy + ADDR_W'(1), '0);
              state      <= FETCH;
            end else begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: three instances (4x4, 3x3, 8 wide x 5 high)
// share clock and reset. Each has a pixel memory returning its own address
// one cycle after a read, and a core model that passes the centre slot through.
module tb_conv_window_ctrl;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic          start4, busy4, done4, rd_en4, out_valid4, ready4;
  logic [AW-1:0] rd_addr4, out_addr4;
  logic [9:0]    rd_data4, conv4, out_data4;
  logic [89:0]   window4;

  logic          start3, busy3, done3, rd_en3, out_valid3, ready3;
  logic [AW-1:0] rd_addr3, out_addr3;
  logic [9:0]    rd_data3, conv3, out_data3;
  logic [89:0]   window3;

  logic          start8, busy8, done8, rd_en8, out_valid8, ready8;
  logic [AW-1:0] rd_addr8, out_addr8;
  logic [9:0]    rd_data8, conv8, out_data8;
  logic [89:0]   window8;

  assign conv4 = window4[49:40];
  assign conv3 = window3[49:40];
  assign conv8 = window8[49:40];

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
    .o_rdEn(rd_en4), .o_rdAddr(rd_addr4), .i_rdData(rd_data4), .o_window(window4),
    .i_convData(conv4), .o_outData(out_data4), .o_outAddr(out_addr4),
    .o_outValid(out_valid4), .i_outReady(ready4)
  );

  conv_window_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .o_busy(busy3), .o_done(done3),
    .o_rdEn(rd_en3), .o_rdAddr(rd_addr3), .i_rdData(rd_data3), .o_window(window3),
    .i_convData(conv3), .o_outData(out_data3), .o_outAddr(out_addr3),
    .o_outValid(out_valid3), .i_outReady(ready3)
  );

  conv_window_ctrl #(.IMG_W(8), .IMG_H(5), .ADDR_W(AW)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .o_busy(busy8), .o_done(done8),
    .o_rdEn(rd_en8), .o_rdAddr(rd_addr8), .i_rdData(rd_data8), .o_window(window8),
    .i_convData(conv8), .o_outData(out_data8), .o_outAddr(out_addr8),
    .o_outValid(out_valid8), .i_outReady(ready8)
  );

  // Pixel memories: pixel value equals its address.
  always_ff @(posedge clk) begin
    if (rd_en4) rd_data4 <= 10'(rd_addr4);
    if (rd_en3) rd_data3 <= 10'(rd_addr3);
    if (rd_en8) rd_data8 <= 10'(rd_addr8);
  end

  int rd4_q[$], res4_q[$], idx4_q[$];
  int rd3_q[$], res3_q[$], idx3_q[$];
  int rd8_q[$], res8_q[$], idx8_q[$];
  int done4_n = 0, done3_n = 0, done8_n = 0;

  // Edge monitor: logs reads, handshakes and done pulses.
  always @(posedge clk) begin
    if (rd_en4) rd4_q.push_back(int'(rd_addr4));
    if (rd_en3) rd3_q.push_back(int'(rd_addr3));
    if (rd_en8) rd8_q.push_back(int'(rd_addr8));
    if (out_valid4 && ready4) begin res4_q.push_back(int'(out_data4)); idx4_q.push_back(int'(out_addr4)); end
    if (out_valid3 && ready3) begin res3_q.push_back(int'(out_data3)); idx3_q.push_back(int'(out_addr3)); end
    if (out_valid8 && ready8) begin res8_q.push_back(int'(out_data8)); idx8_q.push_back(int'(out_addr8)); end
    if (done4) done4_n++;
    if (done3) done3_n++;
    if (done8) done8_n++;
    cyc++;
  end

  int exp_rd4 [24] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11,
                       4, 8, 12, 5, 9, 13, 6, 10, 14, 7, 11, 15};
  int exp_res4 [4] = '{5, 6, 9, 10};
  int exp_rd3 [9]  = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
  int exp_rd8[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Column-major full fetch at row start, then one new column per step.
  task automatic build_exp8();
    exp8_clear();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 6; x++) begin
        if (x == 0) begin
          for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) exp_rd8.push_back((y + r) * 8 + c);
        end else begin
          for (int r = 0; r < 3; r++) exp_rd8.push_back((y + r) * 8 + x + 2);
        end
      end
    end
  endtask

  task automatic exp8_clear();
    exp_rd8.delete();
  endtask

  // Full 4x4 frame with ready held high.
  task automatic run_frame4(input string pfx);
    int t0, tv, ths, tdn, rb, sb, db;
    rb = rd4_q.size(); sb = res4_q.size(); db = done4_n;
    @(negedge clk);
    t0 = cyc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check({pfx, "_busy_rise"}, busy4, 1);
    tv = -1; ths = -1; tdn = -1;
    for (int i = 0; i < 200 && tdn < 0; i++) begin
      if (out_valid4 && tv < 0) tv = cyc;
      if (out_valid4 && ready4) ths = cyc;
      if (done4) begin
        tdn = cyc;
        check({pfx, "_busy_at_done"}, busy4, 0);
      end
      if (tdn < 0) @(negedge clk);
    end
    check({pfx, "_done_seen"}, (tdn >= 0), 1);
    check({pfx, "_first_valid_lat"}, tv - t0, 12);
    check({pfx, "_done_lat"}, tdn - ths, 1);
    repeat (5) @(negedge clk);
    check({pfx, "_done_count"}, done4_n - db, 1);
    check({pfx, "_res_count"}, res4_q.size() - sb, 4);
    for (int i = 0; i < 4 && sb + i < res4_q.size(); i++) begin
      check($sformatf("%s_res%0d", pfx, i), res4_q[sb + i], exp_res4[i]);
      check($sformatf("%s_idx%0d", pfx, i), idx4_q[sb + i], i);
    end
    check({pfx, "_rd_count"}, rd4_q.size() - rb, 24);
    for (int i = 0; i < 24 && rb + i < rd4_q.size(); i++)
      check($sformatf("%s_rd%0d", pfx, i), rd4_q[rb + i], exp_rd4[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rb, sb, db;
    logic [89:0] exp_w3;

    rst = 1'b1;
    start4 = 1'b0; start3 = 1'b0; start8 = 1'b0;
    ready4 = 1'b1; ready3 = 1'b1; ready8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_rd_en", rd_en4, 0);
    check("rst_rd_addr", rd_addr4, 0);
    check("rst_valid", out_valid4, 0);
    check("rst_out_data", out_data4, 0);
    check("rst_out_addr", out_addr4, 0);
    check("rst_window", window4, 0);

    // 4x4 frame
    run_frame4("f4a");

    // Reset during the 5th FETCH cycle of a 4x4 frame
    @(negedge clk);
    t0 = cyc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    check("mr_rd_active", rd_en4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", busy4, 0);
    check("mr_done", done4, 0);
    check("mr_rd_en", rd_en4, 0);
    check("mr_rd_addr", rd_addr4, 0);
    check("mr_valid", out_valid4, 0);
    check("mr_out_data", out_data4, 0);
    check("mr_out_addr", out_addr4, 0);
    check("mr_window", window4, 0);
    @(negedge clk);
    check("mr_window_late", window4, 0);
    check("mr_idle_busy", busy4, 0);
    check("mr_idle_rd", rd_en4, 0);
    run_frame4("f4b");

    // 3x3 frame with start re-pulsed at T+3 and at the last handshake
    rb = rd3_q.size(); sb = res3_q.size(); db = done3_n;
    for (int k = 0; k < 9; k++) exp_w3[10*k +: 10] = 10'(k);
    @(negedge clk);
    t0 = cyc; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (cyc < t0 + 11) @(negedge clk);
    check("f3_window_calc", window3, exp_w3);
    check("f3_valid_calc", out_valid3, 0);
    @(negedge clk);
    check("f3_valid", out_valid3, 1);
    check("f3_data", out_data3, 4);
    check("f3_addr", out_addr3, 0);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("f3_done_pulse", done3, 1);
    check("f3_busy_done", busy3, 0);
    @(negedge clk);
    check("f3_done_clear", done3, 0);
    check("f3_busy_idle", busy3, 0);
    repeat (20) @(negedge clk);
    check("f3_busy_after", busy3, 0);
    check("f3_done_count", done3_n - db, 1);
    check("f3_res_count", res3_q.size() - sb, 1);
    check("f3_rd_count", rd3_q.size() - rb, 9);
    for (int i = 0; i < 9 && rb + i < rd3_q.size(); i++)
      check($sformatf("f3_rd%0d", i), rd3_q[rb + i], exp_rd3[i]);

    // start together with reset is ignored
    @(negedge clk);
    rst = 1'b1; start3 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start3 = 1'b0;
    check("rs_busy", busy3, 0);
    @(negedge clk);
    check("rs_busy2", busy3, 0);
    check("rs_rd_en", rd_en3, 0);

    // 8x5 frame, second result stalled for 5 cycles
    build_exp8();
    rb = rd8_q.size(); sb = res8_q.size(); db = done8_n;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 100 && res8_q.size() < sb + 1; i++) @(negedge clk);
    ready8 = 1'b0;
    check("f8_first_hs", res8_q.size() - sb, 1);
    for (int i = 0; i < 20 && !out_valid8; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("f8_stall_valid%0d", i), out_valid8, 1);
      check($sformatf("f8_stall_data%0d", i), out_data8, 10);
      check($sformatf("f8_stall_addr%0d", i), out_addr8, 1);
      check($sformatf("f8_stall_rd%0d", i), rd_en8, 0);
      @(negedge clk);
    end
    ready8 = 1'b1;
    for (int i = 0; i < 400 && done8_n == db; i++) @(negedge clk);
    check("f8_done_count", done8_n - db, 1);
    check("f8_busy_end", busy8, 0);
    check("f8_res_count", res8_q.size() - sb, 18);
    for (int i = 0; i < 18 && sb + i < res8_q.size(); i++) begin
      check($sformatf("f8_res%0d", i), res8_q[sb + i], (i / 6 + 1) * 8 + (i % 6) + 1);
      check($sformatf("f8_idx%0d", i), idx8_q[sb + i], i);
    end
    check("f8_rd_count", rd8_q.size() - rb, 72);
    for (int i = 0; i < 72 && rb + i < rd8_q.size(); i++)
      check($sformatf("f8_rd%0d", i), rd8_q[rb + i], exp_rd8[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Frame sequencer for the 3x3 convolution core. On a start pulse it walks a stride-1, no-padding 3x3 window over an IMG_H x IMG_W feature map held in an external single-port pixel memory and presents each 90-bit window to the core's data input. It captures the core's 10-bit rectified result and streams one result per window through a valid/ready port. The weight bus of the core is not driven here; weights are held static by the layer controller for the whole frame.

## Interface
- IMG_W, 8: feature-map width in pixels; legal range ≥3.
- IMG_H, 8: feature-map height in pixels; legal range ≥3.
- ADDR_W, 16: width of the pixel and result address buses.
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_start  in  1  one-cycle pulse that starts a frame. Ignored while o_busy=1.
- o_busy  out  1  high from the cycle after an accepted start through the last output handshake cycle.
- o_done  out  1  one-cycle pulse in the cycle after the last output handshake.
- o_rdEn  out  1  pixel read strobe.
- o_rdAddr  out  ADDR_W  pixel address, equal to y*IMG_W + x.
- i_rdData  in  10  pixel data, valid exactly one cycle after o_rdEn.
- o_window  out  90  window to the core; slot k=3*r+c occupies bits [10k+9:10k], where r is the window row and c is the window column.
- i_convData  in  10  core result, combinational from o_window.
- o_outData  out  10  registered result.
- o_outAddr  out  ADDR_W  result index, equal to oy*(IMG_W-2)+ox.
- o_outValid  out  1  result valid.
- i_outReady  in  1  downstream ready.

## Operation
- FSM has five states: IDLE, FETCH, CALC, OUT, DONE.
- IDLE → FETCH on i_start. This sets oy=0 and ox=0.
- FETCH, full mode (ox=0):
  - Issues 9 reads, one per cycle, in column-major order: (oy,0),(oy+1,0),(oy+2,0),(oy,1)…(oy+2,2).
  - Each datum lands in its slot one cycle after its read.
  - The state lasts 10 cycles: 9 issue cycles, then 1 final capture cycle.
- FETCH, shift mode (ox>0):
  - On entry, the window shifts left by one column (slots c0←c1, c1←c2).
  - Issues 3 reads for column ox+2, rows oy..oy+2, into column-2 slots.
  - The state lasts 4 cycles.
- CALC lasts 1 cycle. o_window is stable. The block registers i_convData into o_outData and the current index into o_outAddr, then goes to OUT.
- OUT:
  - o_outValid=1. o_outData and o_outAddr are held stable while i_outReady=0.
  - No reads are issued while in OUT.
  - On a handshake (valid and ready in the same cycle), the next state is:
    - ox<IMG_W-3: ox+1, then FETCH (shift mode).
    - ox=IMG_W-3 and oy<IMG_H-3: ox=0, oy+1, then FETCH (full mode).
    - otherwise: DONE.
- DONE lasts 1 cycle: o_done=1, o_busy=0, then IDLE.
- Per frame:
  - Outputs: (IMG_W-2)*(IMG_H-2).
  - Reads: (IMG_H-2)*(9+3*(IMG_W-3)).
- Reset (including mid-frame):
  - Next state is IDLE.
  - o_busy, o_done, o_rdEn, o_outValid = 0.
  - o_rdAddr, o_outAddr, o_outData = 0.
  - o_window = 0.
  - Any in-flight read data is discarded.
- i_start asserted in the same cycle as i_rst: ignored.

## Timing
- Start accepted at cycle T.
- First window:
  - Reads at T+1..T+9.
  - Last capture at T+10.
  - CALC at T+11.
  - o_outValid=1 from T+12.
- Steady state within a row, with i_outReady held high: 6 cycles per result (4 FETCH + 1 CALC + 1 OUT).
- Row change: 11 cycles per result (10 FETCH + 1 CALC), plus the OUT cycle.
- Last handshake at cycle t: o_done=1 and o_busy=0 at t+1; IDLE at t+2.
- o_rdEn is never high outside FETCH.

## Test plan
Common bench setup: core instantiated with centre weight 10'd512 and all other weights 0, so result = centre pixel. Memory model: pixel = address.

- 4x4 frame, ready always 1:
  - Results 5,6,9,10 at o_outAddr 0,1,2,3.
  - Reads 0,4,8,1,5,9,2,6,10, then 3,7,11, then 4,8,12,5,9,13,6,10,14, then 7,11,15.
  - First o_outValid at T+12; o_done once.
- 3x3 frame:
  - o_window in CALC is {8,7,6,5,4,3,2,1,0}, slot 8 in the MSBs.
  - 9 reads, one result = 4.
- 5x8 frame (IMG_W=8, IMG_H=5) with i_outReady low for 5 cycles on the 2nd result:
  - o_outData=10 and o_outAddr=1 held throughout; no o_rdEn during the stall.
  - After release, row wrap: result index 6 = pixel 17, preceded by a full 9-read fetch.
  - 18 results in total.
- Start re-pulsed at T+3 and at the last-handshake cycle of a 3x3 frame: both ignored; exactly 1 result and 1 o_done.
- Reset asserted during the 5th FETCH cycle of a 4x4 frame:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A subsequent start reproduces scenario 1 exactly.
